miriscv_mem_arbiter: RTL and testbench
======================================

MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk_i and arstn_i.
REQ-002 Parameter MAX_DATA_STREAK, default 3: maximum consecutive data grants while an instruction request waits.
REQ-003 clk_i  in  1  clock; all state changes on its rising edge.
REQ-004 arstn_i  in  1  asynchronous reset, active low.
REQ-005 i_req_i / i_addr_i  in  1/32  instruction-fetch request and its address.
REQ-006 i_rdata_o / i_rvalid_o  out  32/1  fetch read data and its one-cycle completion strobe.
REQ-007 d_req_i / d_we_i / d_be_i / d_addr_i / d_wdata_i  in  1/1/4/32/32  LSU request, write enable, byte enables, address and write data.
REQ-008 d_rdata_o / d_rvalid_o  out  32/1  LSU read data and its one-cycle completion strobe.
REQ-009 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1/1/4/32/32  shared memory request channel.
REQ-010 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1/1/32  memory grant, response strobe and read data.
REQ-011 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, REQ and RSP; at most one transaction SHALL be outstanding.
REQ-013 IDLE: if any requester is pending, the block SHALL select an owner and register owner, we, be, addr and wdata, then move to REQ; otherwise it SHALL stay in IDLE.
REQ-014 Selection: data SHALL win over instruction, except when both are pending and streak == MAX_DATA_STREAK; then instruction SHALL win.
REQ-015 Streak counter: increments on a data grant with i_req_i=1; clears on an instruction grant or on a data grant with i_req_i=0; saturates at MAX_DATA_STREAK.
REQ-016 Instruction transactions SHALL drive mem_we_o=0, mem_be_o=4'b1111 and mem_wdata_o=0.
REQ-017 REQ: mem_req_o=1 with the registered fields held stable; mem_gnt_i=1 moves the FSM to RSP.
REQ-018 REQ with mem_gnt_i=1 and mem_rvalid_i=1 in the same cycle SHALL complete the transaction and move directly to IDLE.
REQ-019 RSP: mem_req_o=0; mem_rvalid_i=1 moves the FSM to IDLE.
REQ-020 Owner rvalid SHALL equal mem_rvalid_i, combinationally, in the completing cycle only; the owner rdata SHALL equal mem_rdata_i in that cycle.
REQ-021 The non-owner rvalid SHALL stay 0; each rdata output SHALL be 0 whenever its rvalid is 0.
REQ-022 mem_rvalid_i outside a completing cycle (IDLE, or REQ without gnt) SHALL be ignored.
REQ-023 A request held high in the cycle after its rvalid SHALL count as a new request; minimum spacing is one IDLE cycle between transactions.
REQ-024 Requesters SHALL hold req and fields stable until their rvalid; a request that drops before it is granted is not served.

Reset
REQ-025 While arstn_i=0: FSM=IDLE, streak=0, registered fields=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, both rvalid=0, busy_o=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction; a late mem_rvalid_i after release SHALL be ignored by REQ-022.

Structure
REQ-027 Package miriscv_mem_pkg SHALL hold the FSM state enum {IDLE, REQ, RSP}, the owner enum {OWN_I, OWN_D} and the MAX_DATA_STREAK default.
REQ-028 Selection and the streak counter SHALL form one sub-module, miriscv_arb_prio; the FSM and datapath registers stay in the top.

Verification
REQ-029 Data only: d_req=1, we=1, be=4'b0011, addr=0x100, wdata=0xA5A5; gnt in the 2nd cycle, rvalid in the 3rd -> mem fields match; d_rvalid pulses once; i_rvalid stays 0.
REQ-030 Both requesters held high, MAX_DATA_STREAK=3 -> grant order D,D,D,I,D,D,D,I.
REQ-031 Zero-latency memory: gnt=rvalid=1 in REQ -> completion in the same cycle; the next request is in REQ two cycles later.
REQ-032 Instruction fetch at addr=0x40, mem_rdata=0x00500093 -> i_rdata_o=0x00500093 with i_rvalid_o; mem_we_o=0, mem_be_o=4'hF.
REQ-033 arstn_i pulsed low in RSP, then mem_rvalid_i=1 after release -> no rvalid on either port; FSM stays in IDLE; mem_req_o=0.
REQ-034 mem_gnt_i held 0 for 10 cycles -> mem_req_o stays high and mem_addr_o stays stable throughout.

Source files
------------

// File: rtl/miriscv_mem_pkg.sv
// miriscv_mem_pkg
//   Shared types for the instruction/data memory arbiter:
//   FSM state encoding, transaction owner encoding and the
//   default data-streak limit.
package miriscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam int unsigned MAX_DATA_STREAK_DEF = 3;

endpackage

// File: rtl/miriscv_arb_prio.sv
// miriscv_arb_prio
//   Owner selection between the fetch and LSU requesters plus the
//   data-streak counter that bounds fetch starvation.
//   clk_i, arstn_i : clock, async active-low reset
//   i_req_i        : fetch request pending
//   d_req_i        : LSU request pending
//   i_grant        : a transaction is being launched this cycle
//   o_owner        : selected owner (valid whenever a request is pending)
module miriscv_arb_prio
   import miriscv_mem_pkg::*;
#(
   parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
   input  logic   clk_i,
   input  logic   arstn_i,
   input  logic   i_req_i,
   input  logic   d_req_i,
   input  logic   i_grant,
   output owner_t o_owner
);

   localparam int unsigned SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);

   logic [SW-1:0] r_streak;
   logic          w_sat;

   assign w_sat = (r_streak == SW'(MAX_DATA_STREAK));

   // Data wins unless a waiting fetch has already seen the full streak.
   always_comb begin
      o_owner = OWN_I;
      if (d_req_i && !(i_req_i && w_sat)) begin
         o_owner = OWN_D;
      end
   end

   // Only data grants that bypass a waiting fetch extend the streak.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_streak <= '0;
      end else if (i_grant) begin
         if (o_owner == OWN_D && i_req_i) begin
            if (!w_sat) begin
               r_streak <= r_streak + 1'b1;
            end
         end else begin
            r_streak <= '0;
         end
      end
   end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// miriscv_mem_arbiter
//   Shares one memory request channel between the instruction fetch
//   and the LSU, one outstanding transaction at a time.
//   clk_i, arstn_i          : clock, async active-low reset
//   i_req_i, i_addr_i       : fetch request / address
//   i_rdata_o, i_rvalid_o   : fetch response
//   d_req_i .. d_wdata_i    : LSU request / we / be / address / wdata
//   d_rdata_o, d_rvalid_o   : LSU response
//   mem_*_o                 : shared memory request channel
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : memory grant and response
//   busy_o                  : a transaction is in flight
module miriscv_mem_arbiter
   import miriscv_mem_pkg::*;
#(
   parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        i_req_i,
   input  logic [31:0] i_addr_i,
   output logic [31:0] i_rdata_o,
   output logic        i_rvalid_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_be_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic [31:0] d_rdata_o,
   output logic        d_rvalid_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   state_t      r_state;
   state_t      w_state_nxt;
   owner_t      r_owner;
   owner_t      w_owner_sel;
   logic        r_we;
   logic [3:0]  r_be;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        w_load;
   logic        w_done;

   assign w_load = (r_state == IDLE) && (i_req_i || d_req_i);

   miriscv_arb_prio #(
      .MAX_DATA_STREAK (MAX_DATA_STREAK)
   ) u_prio (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .i_req_i (i_req_i),
      .d_req_i (d_req_i),
      .i_grant (w_load),
      .o_owner (w_owner_sel)
   );

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // w_done marks the completing cycle; rvalid in any other cycle is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      mem_req_o   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_load) begin
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
               if (mem_rvalid_i) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = RSP;
               end
            end
         end
         RSP: begin
            if (mem_rvalid_i) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_owner <= OWN_I;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_load) begin
         r_owner <= w_owner_sel;
         if (w_owner_sel == OWN_D) begin
            r_we    <= d_we_i;
            r_be    <= d_be_i;
            r_addr  <= d_addr_i;
            r_wdata <= d_wdata_i;
         end else begin
            r_we    <= 1'b0;
            r_be    <= '1;
            r_addr  <= i_addr_i;
            r_wdata <= '0;
         end
      end
   end

   assign mem_we_o    = r_we;
   assign mem_be_o    = r_be;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign busy_o      = (r_state != IDLE);

   assign i_rvalid_o  = w_done && (r_owner == OWN_I);
   assign d_rvalid_o  = w_done && (r_owner == OWN_D);
   assign i_rdata_o   = i_rvalid_o ? mem_rdata_i : '0;
   assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb_miriscv_mem_arbiter
//   Directed scenarios followed by randomized requesters and memory,
//   all checked against a transaction-level reference model.
module tb_miriscv_mem_arbiter;

   localparam int unsigned MAXS = 3;
   localparam logic [31:0] ORD [8] = '{32'h100, 32'h100, 32'h100, 32'h40,
                                       32'h100, 32'h100, 32'h100, 32'h40};

   logic        clk_i;
   logic        arstn_i;
   logic        i_req_i;
   logic [31:0] i_addr_i;
   logic [31:0] i_rdata_o;
   logic        i_rvalid_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [3:0]  d_be_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_rvalid_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   miriscv_mem_arbiter #(
      .MAX_DATA_STREAK (MAXS)
   ) dut (
      .clk_i        (clk_i),
      .arstn_i      (arstn_i),
      .i_req_i      (i_req_i),
      .i_addr_i     (i_addr_i),
      .i_rdata_o    (i_rdata_o),
      .i_rvalid_o   (i_rvalid_o),
      .d_req_i      (d_req_i),
      .d_we_i       (d_we_i),
      .d_be_i       (d_be_i),
      .d_addr_i     (d_addr_i),
      .d_wdata_i    (d_wdata_i),
      .d_rdata_o    (d_rdata_o),
      .d_rvalid_o   (d_rvalid_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .busy_o       (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_irv = 0;
   int unsigned n_drv = 0;

   // Reference model: one in-flight transaction, its launch fields,
   // whether memory accepted it, and the running data streak.
   bit          m_busy, m_acc, m_own_d, m_i_done, m_d_done;
   int unsigned m_streak;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] obs_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step(input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dwe, input logic [3:0] dbe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input bit g, input bit rv, input logic [31:0] rd);
      bit exp_req, done, ei, ed;
      @(negedge clk_i);
      i_req_i = ir;  i_addr_i = ia;
      d_req_i = dr;  d_we_i = dwe; d_be_i = dbe; d_addr_i = da; d_wdata_i = dwd;
      mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
      #1;
      exp_req = m_busy && !m_acc;
      done    = m_busy && rv && (m_acc || g);
      ei      = done && !m_own_d;
      ed      = done && m_own_d;
      chk("mem_req", mem_req_o, exp_req);
      chk("busy", busy_o, m_busy);
      chk("i_rvalid", i_rvalid_o, ei);
      chk("d_rvalid", d_rvalid_o, ed);
      chk("i_rdata", i_rdata_o, ei ? rd : 32'h0);
      chk("d_rdata", d_rdata_o, ed ? rd : 32'h0);
      if (exp_req) begin
         chk("mem_addr", mem_addr_o, m_addr);
         chk("mem_we", mem_we_o, m_we);
         chk("mem_be", mem_be_o, m_be);
         chk("mem_wdata", mem_wdata_o, m_wdata);
      end
      if (mem_req_o) obs_q.push_back(mem_addr_o);
      n_irv += i_rvalid_o;
      n_drv += d_rvalid_o;
      m_i_done = ei;
      m_d_done = ed;
      if (!m_busy) begin
         if (ir || dr) begin
            m_own_d = dr && !(ir && m_streak == MAXS);
            if (m_own_d) begin
               m_streak = ir ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
               m_we = dwe; m_be = dbe; m_addr = da; m_wdata = dwd;
            end else begin
               m_streak = 0;
               m_we = 1'b0; m_be = 4'hF; m_addr = ia; m_wdata = 32'h0;
            end
            m_busy = 1'b1;
            m_acc  = 1'b0;
         end
      end else if (done) begin
         m_busy = 1'b0;
      end else if (!m_acc && g) begin
         m_acc = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      arstn_i = 1'b0;
      i_req_i = 1'b0; d_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
      mem_rdata_i = 32'hDEAD_BEEF;
      #1;
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_mem_we", mem_we_o, 1'b0);
      chk("rst_mem_be", mem_be_o, 4'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_i_rvalid", i_rvalid_o, 1'b0);
      chk("rst_d_rvalid", d_rvalid_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      @(negedge clk_i);
      arstn_i = 1'b1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      m_busy = 0; m_acc = 0; m_streak = 0; m_i_done = 0; m_d_done = 0;
      n_irv = 0; n_drv = 0;
      obs_q.delete();
   endtask

   initial begin
      bit          ip, dp, dwe, g, rv;
      logic [31:0] ia, da, dwd;
      logic [3:0]  dbe;

      arstn_i = 1'b0;
      i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_we_i = 0; d_be_i = 0;
      d_addr_i = 0; d_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
      do_reset();

      // LSU write: grant in the 2nd cycle, response in the 3rd.
      step(0, 0, 1, 1, 4'b0011, 32'h100, 32'hA5A5, 0, 0, 32'h0);
      step(0, 0, 1, 1, 4'b0011, 32'h100, 32'hA5A5, 1, 0, 32'h0);
      step(0, 0, 1, 1, 4'b0011, 32'h100, 32'hA5A5, 0, 1, 32'h1234_5678);
      step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("wr_d_pulses", n_drv, 1);
      chk("wr_i_pulses", n_irv, 0);

      // Instruction fetch.
      n_irv = 0;
      step(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
      step(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
      step(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0050_0093);
      step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("if_i_pulses", n_irv, 1);

      // Grant withheld for 10 cycles.
      obs_q.delete();
      for (int i = 0; i < 11; i++)
         step(0, 0, 1, 0, 4'hC, 32'h0000_0200, 32'h77, 0, i[0], 32'h0);
      step(0, 0, 1, 0, 4'hC, 32'h0000_0200, 32'h77, 1, 1, 32'h0);
      chk("stall_len", obs_q.size(), 11);
      foreach (obs_q[k]) chk("stall_addr", obs_q[k], 32'h200);
      step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

      // Zero-latency memory, request held across completion.
      step(0, 0, 1, 1, 4'hF, 32'h300, 32'h1, 0, 0, 32'h0);
      step(0, 0, 1, 1, 4'hF, 32'h300, 32'h1, 1, 1, 32'hAA);
      step(0, 0, 1, 1, 4'hF, 32'h300, 32'h1, 0, 0, 32'h0);
      step(0, 0, 1, 1, 4'hF, 32'h300, 32'h1, 0, 0, 32'h0);
      chk("zl_req_again", mem_req_o, 1'b1);
      step(0, 0, 1, 1, 4'hF, 32'h300, 32'h1, 1, 1, 32'hBB);
      step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

      // Both requesters held high: fairness order.
      do_reset();
      for (int i = 0; i < 16; i++)
         step(1, 32'h40, 1, 0, 4'h1, 32'h100, 32'h0, 1, 1, 32'h5);
      chk("order_len", obs_q.size(), 8);
      for (int k = 0; k < 8 && k < obs_q.size(); k++) chk("order", obs_q[k], ORD[k]);
      step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

      // Reset while waiting for the response, then a late rvalid.
      step(0, 0, 1, 0, 4'h1, 32'h500, 32'h0, 0, 0, 32'h0);
      step(0, 0, 1, 0, 4'h1, 32'h500, 32'h0, 1, 0, 32'h0);
      chk("pre_rst_busy", busy_o, 1'b1);
      do_reset();
      step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hCAFE);
      step(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
      chk("late_rv_i", n_irv, 0);
      chk("late_rv_d", n_drv, 0);

      // Randomized traffic.
      do_reset();
      ip = 0; dp = 0; ia = 0; da = 0; dwd = 0; dbe = 0; dwe = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!ip || m_i_done) begin
            ip = ($urandom_range(0, 1) == 1);
            ia = $urandom;
         end
         if (!dp || m_d_done) begin
            dp = ($urandom_range(0, 2) != 0);
            dwe = ($urandom_range(0, 1) == 1);
            dbe = 4'($urandom);
            da  = $urandom;
            dwd = $urandom;
         end
         g = ($urandom_range(0, 1) == 1);
         if (m_busy && m_acc)      rv = ($urandom_range(0, 9) < 4);
         else if (m_busy && g)     rv = ($urandom_range(0, 9) < 3);
         else                      rv = ($urandom_range(0, 19) < 3);
         step(ip, ia, dp, dwe, dbe, da, dwd, g, rv, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
